// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_types_pkg
// Brief    : Shared CPU/memory types used by the memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DGNT = 2'd1,
    IGNT = 2'd2,
    ERR  = 2'd3
  } memarb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : mem_watchdog
// Brief    : Grant-wait counter; flags expiry on the TIMEOUT-th counted cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mem_watchdog #(
  parameter int TIMEOUT = 16,
  parameter int WIDTH   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(TIMEOUT - 1);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  // count holds the cycles already spent, so the current cycle is count+1
  assign expired = en && (count >= LAST);

endmodule
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter
// Brief    : Single-port RAM arbiter, data-priority with bounded run, watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT   = 16,
  parameter int MAX_D_RUN = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output word_t     iload,
  output logic      ihit,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output word_t     dload,
  output logic      dhit,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      memerr
);

  localparam int DRUN_W = ($clog2(MAX_D_RUN + 1) < 3) ? 3 : $clog2(MAX_D_RUN + 1);
  localparam logic [DRUN_W-1:0] DRUN_MAX = DRUN_W'(MAX_D_RUN);

  memarb_state_t     state;
  logic [DRUN_W-1:0] drun;

  logic d_req, d_read, in_grant, gnt_req, access, fault, leave;
  logic go_d, go_i, wd_clear, wd_expired;

  always_comb begin
    d_req    = dREN | dWEN;
    d_read   = dREN & ~dWEN;
    in_grant = (state == DGNT) || (state == IGNT);
    gnt_req  = (state == DGNT) ? d_req : ((state == IGNT) ? iREN : 1'b0);
    access   = in_grant && (ramstate == ACCESS) && gnt_req;
    // ERROR beats withdrawal; ACCESS beats timeout
    fault    = in_grant && ((ramstate == ERROR) || (wd_expired && gnt_req && !access));
    leave    = in_grant && (fault || access || !gnt_req);
    go_d     = (state == IDLE) && d_req && !(iREN && (drun == DRUN_MAX));
    go_i     = (state == IDLE) && !go_d && iREN;
    wd_clear = !in_grant || leave;
  end

  mem_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (CLK),
    .rst_n   (nRST),
    .clear   (wd_clear),
    .en      (in_grant),
    .expired (wd_expired)
  );

  always_comb begin
    iload    = '0;
    dload    = '0;
    ihit     = 1'b0;
    dhit     = 1'b0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = d_read;
        dhit     = access;
        dload    = (access && d_read) ? ramload : '0;
      end
      IGNT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        ihit    = access;
        iload   = access ? ramload : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      drun   <= '0;
      memerr <= 1'b0;
    end else begin
      if (!iREN || go_i) begin
        drun <= '0;
      end else if (go_d && (drun != '1)) begin
        drun <= drun + 1'b1;
      end

      case (state)
        IDLE: begin
          if (go_d) begin
            state <= DGNT;
          end else if (go_i) begin
            state <= IGNT;
          end
        end
        DGNT, IGNT: begin
          if (fault) begin
            state  <= ERR;
            memerr <= 1'b1;
          end else if (leave) begin
            state <= IDLE;
          end
        end
        ERR: begin
          memerr <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
